// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WRITE,
    SETTLE
  } arb_state_e;

  localparam int TX_FULL_BIT = 0;

  // Next round-robin index after id, wrapping at n.
  function automatic int rr_inc(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Rotate-priority picker: first valid index found scanning ptr, ptr+1, ... mod NUM_REQ.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  logic [ID_W-1:0] idx;

  // Scan from the far end so the candidate nearest ptr is written last and wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter feeding one UART transmit FIFO from NUM_REQ requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 255,
  parameter int FULL_BIT     = TX_FULL_BIT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [7:0]                   tx_status,
  output logic                         write_data,
  output logic [DATA_SIZE-1:0]         bus_data,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy
);

  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam int TO_W = $clog2(HOLD_TIMEOUT + 1);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [BC_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 last_q, last_d;
  logic [DATA_SIZE-1:0] bus_data_q, bus_data_d;
  logic                 write_q, write_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0][DATA_SIZE-1:0] req_bytes;
  logic [ID_W-1:0]                   winner;
  logic                              any_valid;
  logic                              tx_full;
  logic                              g_valid;
  logic                              unused_status;

  assign req_bytes     = req_data;
  assign tx_full       = tx_status[FULL_BIT];
  assign g_valid       = req_valid[grant_q];
  assign unused_status = ^tx_status;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    last_d     = last_q;
    bus_data_d = bus_data_q;
    write_d    = 1'b0;
    busy_d     = busy_q;
    req_ready  = '0;

    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d    = winner;
          busy_d     = 1'b1;
          byte_cnt_d = '0;
          to_cnt_d   = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        req_ready[grant_q] = !tx_full;
        if (g_valid && !tx_full) begin
          bus_data_d = req_bytes[grant_q];
          last_d     = req_last[grant_q];
          byte_cnt_d = byte_cnt_q + BC_W'(1);
          to_cnt_d   = '0;
          write_d    = 1'b1;
          state_d    = WRITE;
        end else if (!g_valid) begin
          // Only an absent requester ages the grant; a stalled FIFO does not.
          if (int'(to_cnt_q) < HOLD_TIMEOUT) to_cnt_d = to_cnt_q + TO_W'(1);
          if (int'(to_cnt_q) + 1 >= HOLD_TIMEOUT) begin
            busy_d  = 1'b0;
            ptr_d   = ID_W'(rr_inc(int'(grant_q), NUM_REQ));
            state_d = IDLE;
          end
        end
      end
      WRITE: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        // Dead cycle lets the FIFO-full flag catch up with the write just issued.
        if (last_q || int'(byte_cnt_q) == MAX_BURST) begin
          busy_d  = 1'b0;
          ptr_d   = ID_W'(rr_inc(int'(grant_q), NUM_REQ));
          state_d = IDLE;
        end else begin
          state_d = XFER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      last_q     <= 1'b0;
      bus_data_q <= '0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      last_q     <= last_d;
      bus_data_q <= bus_data_d;
      write_q    <= write_d;
      busy_q     <= busy_d;
    end
  end

  assign write_data = write_q;
  assign bus_data   = bus_data_q;
  assign grant_id   = grant_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: randomized traffic against a packet-level rotation model plus directed boundaries.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int MAXB = 16;
  localparam int HOLD = 255;

  logic        clk, reset_n;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic [7:0]  tx_status;
  logic        write_data;
  logic [7:0]  bus_data;
  logic [1:0]  grant_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] src_d [NR][64];
  logic       src_l [NR][64];
  int         src_len [NR];
  int         src_idx [NR];
  int         m_ptr;
  int         exp_id [$];
  logic [7:0] exp_d [$];
  int         wcyc [$];

  uart_tx_arbiter #(
    .DATA_SIZE(8), .NUM_REQ(NR), .ID_W(2), .MAX_BURST(MAXB),
    .HOLD_TIMEOUT(HOLD), .FULL_BIT(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_status(tx_status),
    .write_data(write_data), .bus_data(bus_data), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Expected write order: strict rotation from m_ptr, each grant serving until
  // last, MAX_BURST bytes, or the requester running dry (timeout).
  task automatic build_expected();
    int pos [NR];
    int w, n, c;
    bit stop;
    for (int i = 0; i < NR; i++) pos[i] = 0;
    for (int g = 0; g < 1000; g++) begin
      w = -1;
      for (int k = 0; k < NR; k++) begin
        c = (m_ptr + k) % NR;
        if (w < 0 && pos[c] < src_len[c]) w = c;
      end
      if (w < 0) break;
      n = 0;
      stop = 1'b0;
      while (!stop) begin
        exp_id.push_back(w);
        exp_d.push_back(src_d[w][pos[w]]);
        n++;
        stop = src_l[w][pos[w]] || n == MAXB || pos[w] + 1 >= src_len[w];
        pos[w]++;
      end
      m_ptr = (w + 1) % NR;
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < NR; i++) src_len[i] = 0;
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic l);
    src_d[r][src_len[r]] = d;
    src_l[r][src_len[r]] = l;
    src_len[r]++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_status = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic run_traffic(input int full_pct, input int budget);
    int cyc, eid;
    bit done, all_in;
    logic hs_prev;
    logic [3:0] hs;
    logic [7:0] ed;
    logic [31:0] r;
    exp_id.delete(); exp_d.delete(); wcyc.delete();
    build_expected();
    for (int i = 0; i < NR; i++) src_idx[i] = 0;
    cyc = 0; done = 1'b0; hs_prev = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      total++;
      if (write_data !== hs_prev) begin
        bad++;
        $display("FAIL write_latency cyc=%0d got=%b want=%b", cyc, write_data, hs_prev);
      end
      if (write_data === 1'b1) begin
        total++;
        if (exp_d.size() == 0) begin
          bad++;
          $display("FAIL extra_write got id=%0d data=%h want none", grant_id, bus_data);
        end else begin
          eid = exp_id.pop_front();
          ed  = exp_d.pop_front();
          if (int'(grant_id) != eid || bus_data !== ed) begin
            bad++;
            $display("FAIL write_order got id=%0d data=%h want id=%0d data=%h", grant_id, bus_data, eid, ed);
          end
        end
        wcyc.push_back(cyc);
      end
      total++;
      if ($countones(req_ready) > 1) begin
        bad++;
        $display("FAIL ready_onehot got=%b want at most one bit", req_ready);
      end
      all_in = 1'b1;
      for (int i = 0; i < NR; i++) begin
        if (src_idx[i] < src_len[i]) begin
          all_in = 1'b0;
          req_valid[i] = 1'b1;
          req_data[i*8 +: 8] = src_d[i][src_idx[i]];
          req_last[i] = src_l[i][src_idx[i]];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      r = $urandom;
      tx_status = {r[7:1], int'(r[31:24] % 8'd100) < full_pct};
      done = all_in && exp_d.size() == 0 && busy === 1'b0 && write_data === 1'b0;
      if (!done) begin
        #1 hs = req_valid & req_ready;
        @(posedge clk);
        for (int i = 0; i < NR; i++) if (hs[i]) src_idx[i]++;
        hs_prev = |hs;
      end
    end
    tx_status = '0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL traffic_budget got cycles=%0d pending=%0d want drained", cyc, exp_d.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 4'hF; req_last = 4'hF; req_data = $urandom; tx_status = '0;
    repeat (2) @(negedge clk);
    total++;
    if (write_data !== 1'b0 || bus_data !== 8'h00 || grant_id !== 2'd0 || busy !== 1'b0 || req_ready !== 4'h0) begin
      bad++;
      $display("FAIL reset_state got w=%b d=%h g=%0d b=%b r=%b want all zero", write_data, bus_data, grant_id, busy, req_ready);
    end
    req_valid = '0;
    reset_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    total++;
    if (write_data !== 1'b0 || busy !== 1'b0 || req_ready !== 4'h0) begin
      bad++;
      $display("FAIL reset_idle got w=%b b=%b r=%b want 0 0 0000", write_data, busy, req_ready);
    end
  endtask

  task automatic test_single();
    apply_reset();
    clear_src();
    add_byte(1, 8'hA1, 1'b0);
    add_byte(1, 8'hA2, 1'b0);
    add_byte(1, 8'hA3, 1'b1);
    run_traffic(0, 100);
    total++;
    if (wcyc.size() != 3) begin
      bad++;
      $display("FAIL single_count got=%0d want=3", wcyc.size());
    end else begin
      total++;
      if (wcyc[1] - wcyc[0] != 3 || wcyc[2] - wcyc[1] != 3) begin
        bad++;
        $display("FAIL single_spacing got=%0d,%0d want=3,3", wcyc[1] - wcyc[0], wcyc[2] - wcyc[1]);
      end
    end
    total++;
    if (grant_id !== 2'd1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_release got g=%0d b=%b want g=1 b=0", grant_id, busy);
    end
    // Pointer now sits at 2, so four one-byte packets must start from requester 2.
    clear_src();
    for (int i = 0; i < NR; i++) add_byte(i, 8'h50 + 8'(i), 1'b1);
    run_traffic(0, 100);
  endtask

  task automatic test_rr();
    apply_reset();
    for (int rep = 0; rep < 2; rep++) begin
      clear_src();
      for (int i = 0; i < NR; i++) add_byte(i, 8'($urandom), 1'b1);
      run_traffic(0, 100);
    end
  endtask

  task automatic test_burst();
    apply_reset();
    clear_src();
    for (int b = 0; b < 20; b++) add_byte(0, 8'($urandom), 1'b0);
    add_byte(2, 8'hC0, 1'b0);
    add_byte(2, 8'hC1, 1'b0);
    add_byte(2, 8'hC2, 1'b1);
    run_traffic(0, 1000);
  endtask

  task automatic test_random();
    int np, len;
    for (int it = 0; it < 4; it++) begin
      clear_src();
      for (int i = 0; i < NR; i++) begin
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 20);
          for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), b == len - 1);
        end
      end
      run_traffic(30, 6000);
    end
  endtask

  task automatic test_full();
    apply_reset();
    tx_status = 8'h01; req_valid = 4'b1000; req_data = 32'h5C00_0000; req_last = 4'b1000;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      total++;
      if (req_ready !== 4'h0 || write_data !== 1'b0) begin
        bad++;
        $display("FAIL full_stall cyc=%0d got r=%b w=%b want 0000 0", c, req_ready, write_data);
      end
    end
    total++;
    if (busy !== 1'b1 || grant_id !== 2'd3) begin
      bad++;
      $display("FAIL full_hold got b=%b g=%0d want b=1 g=3", busy, grant_id);
    end
    tx_status = 8'h00;
    #1;
    total++;
    if (req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL full_clear_ready got=%b want=1000", req_ready);
    end
    @(negedge clk);
    total++;
    if (write_data !== 1'b1 || bus_data !== 8'h5C) begin
      bad++;
      $display("FAIL full_write got w=%b d=%h want 1 5c", write_data, bus_data);
    end
    req_valid = '0;
    tx_status = 8'h01;
    @(negedge clk);
    total++;
    if (write_data !== 1'b0) begin
      bad++;
      $display("FAIL full_pulse_width got=%b want=0", write_data);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || bus_data !== 8'h5C) begin
      bad++;
      $display("FAIL full_release got b=%b d=%h want 0 5c", busy, bus_data);
    end
    tx_status = 8'h00;
  endtask

  task automatic test_timeout();
    bit got, rel;
    int n;
    apply_reset();
    req_valid = 4'b0110; req_data = 32'h0032_3100; req_last = 4'b0100; tx_status = '0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (req_ready[1] === 1'b1) begin
        got = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL timeout_grant got no ready on 1 want ready");
    end
    n = 0; rel = 1'b0;
    for (int c = 0; c < 400 && !rel; c++) begin
      @(negedge clk);
      if (write_data === 1'b1) begin
        total++;
        if (bus_data !== 8'h31) begin
          bad++;
          $display("FAIL timeout_byte got=%h want=31", bus_data);
        end
      end
      total++;
      if (req_ready[2] !== 1'b0) begin
        bad++;
        $display("FAIL timeout_foreign_ready got=%b want=0", req_ready[2]);
      end
      if (busy === 1'b0) rel = 1'b1;
      else if (req_ready[1] === 1'b1) n++;
    end
    total++;
    if (n != HOLD) begin
      bad++;
      $display("FAIL timeout_len got=%0d want=%0d", n, HOLD);
    end
    total++;
    if (grant_id !== 2'd1) begin
      bad++;
      $display("FAIL timeout_grant_hold got=%0d want=1", grant_id);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL timeout_regrant got b=%b g=%0d want b=1 g=2", busy, grant_id);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    apply_reset();
    clear_src();
    add_byte(1, 8'h11, 1'b1);
    run_traffic(0, 100);
    req_valid = 4'b0100; req_data = 32'h0022_0000; req_last = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (write_data === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL midreset_setup got no write want write");
    end
    #1 reset_n = 1'b0;
    req_valid = '0;
    #1;
    total++;
    if (write_data !== 1'b0 || busy !== 1'b0 || bus_data !== 8'h00 || grant_id !== 2'd0 || req_ready !== 4'h0) begin
      bad++;
      $display("FAIL midreset_clear got w=%b b=%b d=%h g=%0d r=%b want all zero", write_data, busy, bus_data, grant_id, req_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (write_data !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL midreset_stale cyc=%0d got w=%b b=%b want 0 0", c, write_data, busy);
      end
    end
    req_valid = 4'b1001; req_data = 32'hD300_00A0; req_last = 4'b1001;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL midreset_ptr got b=%b g=%0d want b=1 g=0", busy, grant_id);
    end
    req_valid = '0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_status = '0; m_ptr = 0;
    test_reset();
    test_single();
    test_rr();
    test_burst();
    test_random();
    test_full();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
